// File: rtl/dffers_univ_reg.sv
// WIDTH-bit universal register/counter: reset > set > enable priority, then one of
// eight modes (hold, load, shift, rotate, modulo count up/down).
module dffers_univ_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}}
) (
   input  logic             SW0,
   input  logic             SW1,
   input  logic             SW2,
   input  logic             SW3,
   input  logic [2:0]       MODE,
   input  logic             SIN,
   input  logic [WIDTH-1:0] DIN,
   output logic [WIDTH-1:0] LED,
   output logic             SOUT,
   output logic             TC
);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_ROL   = 3'b100,
      MODE_ROR   = 3'b101,
      MODE_CUP   = 3'b110,
      MODE_CDN   = 3'b111
   } mode_e;

   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   mode_e            mode_s;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt_s;

   assign mode_s = mode_e'(MODE);

   // Mode action applied when the register is enabled.
   always_comb begin
      q_nxt_s = q_r;
      case (mode_s)
         MODE_HOLD: q_nxt_s = q_r;
         MODE_LOAD: q_nxt_s = DIN;
         MODE_SHL:  q_nxt_s = {q_r[WIDTH-2:0], SIN};
         MODE_SHR:  q_nxt_s = {SIN, q_r[WIDTH-1:1]};
         MODE_ROL:  q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
         MODE_ROR:  q_nxt_s = {q_r[0], q_r[WIDTH-1:1]};
         MODE_CUP: begin
            // Out-of-range values fold back to zero on the next step.
            if (q_r >= MAX) begin
               q_nxt_s = ZERO_C;
            end else begin
               q_nxt_s = q_r + ONE_C;
            end
         end
         MODE_CDN: begin
            if ((q_r == ZERO_C) || (q_r > MAX)) begin
               q_nxt_s = MAX;
            end else begin
               q_nxt_s = q_r - ONE_C;
            end
         end
         default:   q_nxt_s = q_r;
      endcase
   end

   // Register with reset > set > enable priority.
   always_ff @(posedge SW0) begin
      if (SW1) begin
         q_r <= ZERO_C;
      end else if (SW2) begin
         q_r <= SET_VALUE;
      end else if (SW3) begin
         q_r <= q_nxt_s;
      end else begin
         q_r <= q_r;
      end
   end

   // Serial output and terminal count follow Q and MODE without latency.
   always_comb begin
      SOUT = q_r[0];
      TC   = 1'b0;
      case (mode_s)
         MODE_SHL, MODE_ROL: SOUT = q_r[WIDTH-1];
         default:            SOUT = q_r[0];
      endcase
      if (SW3 && (mode_s == MODE_CUP) && (q_r == MAX)) begin
         TC = 1'b1;
      end else if (SW3 && (mode_s == MODE_CDN) && (q_r == ZERO_C)) begin
         TC = 1'b1;
      end else begin
         TC = 1'b0;
      end
   end

   assign LED = q_r;

endmodule

// File: tb/tb_dffers_univ_reg.sv
// Table-driven bench for dffers_univ_reg (WIDTH=4, SET_VALUE=F, MAX=9) plus
// hand-written sequences for combinational SOUT/TC behaviour.
module tb_dffers_univ_reg;

   logic       SW0 = 1'b0;
   logic       SW1 = 1'b0;
   logic       SW2 = 1'b0;
   logic       SW3 = 1'b0;
   logic [2:0] MODE = 3'b000;
   logic       SIN = 1'b0;
   logic [3:0] DIN = 4'h0;
   logic [3:0] LED;
   logic       SOUT;
   logic       TC;

   int checks = 0;
   int errors = 0;

   dffers_univ_reg #(.WIDTH(4), .SET_VALUE(4'hF), .MAX(4'h9)) dut (
      .SW0(SW0), .SW1(SW1), .SW2(SW2), .SW3(SW3), .MODE(MODE),
      .SIN(SIN), .DIN(DIN), .LED(LED), .SOUT(SOUT), .TC(TC)
   );

   always #5 SW0 = ~SW0;

   typedef struct {
      logic       sw1, sw2, sw3;
      logic [2:0] mode;
      logic       sin;
      logic [3:0] din;
      logic [3:0] led;
      logic       sout, tc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic sw1, input logic sw2, input logic sw3, input logic [2:0] mode,
                      input logic sin, input logic [3:0] din, input logic [3:0] led,
                      input logic sout, input logic tc);
      vec_t v;
      v.sw1 = sw1; v.sw2 = sw2; v.sw3 = sw3; v.mode = mode; v.sin = sin; v.din = din;
      v.led = led; v.sout = sout; v.tc = tc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sw1, input logic sw2, input logic sw3, input logic [2:0] mode,
                        input logic sin, input logic [3:0] din);
      SW1 = sw1; SW2 = sw2; SW3 = sw3; MODE = mode; SIN = sin; DIN = din;
   endtask

   initial begin
      //  sw1 sw2 sw3 mode    sin din     led    sout tc
      add(1, 1, 1, 3'b001, 0, 4'h5,  4'h0, 0, 0);  // reset wins
      add(0, 1, 1, 3'b001, 0, 4'h5,  4'hF, 1, 0);  // set wins over load
      add(0, 0, 1, 3'b001, 0, 4'h5,  4'h5, 1, 0);
      add(0, 0, 1, 3'b001, 0, 4'h3,  4'h3, 1, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 3'b110, 0, 4'h0, 4'h3, 1, 0);
      add(0, 0, 1, 3'b110, 0, 4'h0,  4'h4, 0, 0);
      add(0, 0, 1, 3'b001, 0, 4'h8,  4'h8, 0, 0);  // count-up wrap
      add(0, 0, 1, 3'b110, 0, 4'h0,  4'h9, 1, 1);
      add(0, 0, 1, 3'b110, 0, 4'h0,  4'h0, 0, 0);
      add(0, 0, 1, 3'b110, 0, 4'h0,  4'h1, 1, 0);
      add(0, 0, 1, 3'b001, 0, 4'h0,  4'h0, 0, 0);  // count-down wrap
      add(0, 0, 1, 3'b111, 0, 4'h0,  4'h9, 1, 0);
      add(0, 1, 1, 3'b111, 0, 4'h0,  4'hF, 1, 0);  // out of range down
      add(0, 0, 1, 3'b111, 0, 4'h0,  4'h9, 1, 0);
      add(0, 1, 1, 3'b110, 0, 4'h0,  4'hF, 1, 0);  // out of range up
      add(0, 0, 1, 3'b110, 0, 4'h0,  4'h0, 0, 0);
      add(0, 0, 1, 3'b001, 0, 4'h9,  4'h9, 1, 0);  // shift/rotate
      add(0, 0, 1, 3'b010, 0, 4'h0,  4'h2, 0, 0);
      add(0, 0, 1, 3'b101, 0, 4'h0,  4'h1, 1, 0);
      add(0, 0, 1, 3'b011, 1, 4'h0,  4'h8, 0, 0);
      add(0, 0, 1, 3'b100, 0, 4'h0,  4'h1, 0, 0);
      add(0, 0, 1, 3'b010, 1, 4'h0,  4'h3, 0, 0);
      add(0, 0, 1, 3'b000, 1, 4'hA,  4'h3, 1, 0);  // hold mode
      add(0, 0, 1, 3'b001, 0, 4'h5,  4'h5, 1, 0);  // reset mid-count
      add(0, 0, 1, 3'b110, 0, 4'h0,  4'h6, 0, 0);
      add(1, 0, 1, 3'b110, 0, 4'h0,  4'h0, 0, 0);
      add(0, 0, 1, 3'b110, 0, 4'h0,  4'h1, 1, 0);
      add(0, 0, 1, 3'b111, 0, 4'h0,  4'h0, 0, 1);
      add(0, 0, 1, 3'b111, 0, 4'h0,  4'h9, 1, 0);
      add(0, 0, 1, 3'b111, 0, 4'h0,  4'h8, 0, 0);

      @(negedge SW0);
      foreach (vecs[i]) begin
         drive(vecs[i].sw1, vecs[i].sw2, vecs[i].sw3, vecs[i].mode, vecs[i].sin, vecs[i].din);
         @(posedge SW0); #1;
         check($sformatf("vec%0d LED", i), 32'(LED), 32'(vecs[i].led));
         check($sformatf("vec%0d SOUT", i), 32'(SOUT), 32'(vecs[i].sout));
         check($sformatf("vec%0d TC", i), 32'(TC), 32'(vecs[i].tc));
      end

      // TC after reset with count-down selected, and its gating
      drive(1, 0, 0, 3'b000, 0, 4'h0);
      @(posedge SW0); #1;
      check("rst LED", 32'(LED), 32'h0);
      check("rst SOUT", 32'(SOUT), 32'h0);
      check("rst TC", 32'(TC), 32'h0);
      drive(0, 0, 1, 3'b111, 0, 4'h0); #1;
      check("tc down zero", 32'(TC), 32'h1);
      SW3 = 1'b0; #1;
      check("tc gated off", 32'(TC), 32'h0);
      SW1 = 1'b1; SW3 = 1'b1; #1;
      check("tc not gated by sw1", 32'(TC), 32'h1);
      SW1 = 1'b0; MODE = 3'b110; #1;
      check("tc up at zero", 32'(TC), 32'h0);

      // SOUT source follows MODE combinationally
      drive(0, 0, 1, 3'b001, 0, 4'h8);
      @(posedge SW0); #1;
      MODE = 3'b010; #1; check("sout shl", 32'(SOUT), 32'h1);
      MODE = 3'b011; #1; check("sout shr", 32'(SOUT), 32'h0);
      MODE = 3'b100; #1; check("sout rol", 32'(SOUT), 32'h1);
      MODE = 3'b101; #1; check("sout ror", 32'(SOUT), 32'h0);

      // TC at MAX while counting up, dropped by enable
      drive(0, 0, 1, 3'b001, 0, 4'h9);
      @(posedge SW0); #1;
      MODE = 3'b110; #1; check("tc at max", 32'(TC), 32'h1);
      SW3 = 1'b0; #1;    check("tc max gated", 32'(TC), 32'h0);
      MODE = 3'b111; SW3 = 1'b1; #1; check("tc down at max", 32'(TC), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
